video_pll_ctrl: RTL

Reset/lock sequencer for the video PLL. It runs on the free-running 50 MHz reference clock. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and filters lock for stability. It then releases a synchronous reset to the video clock-domain logic, and supervises lock loss during operation. It sits beside the video PLL instance; its `pll_rst` drives the PLL reset and the PLL `pll_lock` output feeds back into this block.

---
 rtl/video_pll_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/video_pll_ctrl.sv
// Video PLL reset/lock sequencer: PLL reset pulse, lock wait with timeout and retries, stability filter.
// Optional `VIDEO_PLL_CTRL_AUTO_RELOCK_EN: lock loss in READY restarts the sequence instead of parking in LOST.
module video_pll_ctrl #(
  parameter int RST_HOLD_CYC     = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 7
) (
  input  logic       clkin1,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int MAX_A   = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_READY  = 3'd3;
`ifndef VIDEO_PLL_CTRL_AUTO_RELOCK_EN
  localparam logic [2:0] ST_LOST   = 3'd4;
`endif
  localparam logic [2:0] ST_FAIL   = 3'd5;

  logic          sync1;
  logic          lock_s;
  logic [2:0]    state;
  logic [2:0]    nxt_state;
  logic [CW-1:0] cnt;
  logic [1:0]    low_run;
  logic [3:0]    nxt_retry;
  logic          lock_lost;

  // Fourth consecutive low sample in READY counts as a real loss of lock.
  assign lock_lost = !lock_s && (low_run == 2'd3);

  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    if (relock_req && state != ST_RESET) begin
      nxt_state = ST_RESET;
      nxt_retry = 4'd0;
    end else begin
      case (state)
        ST_RESET: begin
          if (cnt == RST_LAST) nxt_state = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) begin
            nxt_state = ST_STABLE;
          end else if (cnt == TO_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              nxt_state = ST_FAIL;
            end else begin
              nxt_retry = retry_cnt + 4'd1;
              nxt_state = ST_RESET;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            nxt_state = ST_WAIT;
          end else if (cnt == STB_LAST) begin
            nxt_state = ST_READY;
            nxt_retry = 4'd0;
          end
        end
        ST_READY: begin
          if (lock_lost) begin
`ifdef VIDEO_PLL_CTRL_AUTO_RELOCK_EN
            nxt_state = ST_RESET;
            nxt_retry = 4'd0;
`else
            nxt_state = ST_LOST;
`endif
          end
        end
`ifndef VIDEO_PLL_CTRL_AUTO_RELOCK_EN
        ST_LOST: nxt_state = ST_LOST;
`endif
        ST_FAIL: nxt_state = ST_FAIL;
        default: nxt_state = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clkin1) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      lock_s      <= 1'b0;
      state       <= ST_RESET;
      cnt         <= '0;
      low_run     <= 2'd0;
      retry_cnt   <= 4'd0;
      pll_rst     <= 1'b1;
      video_rst_n <= 1'b0;
      pll_ready   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      sync1     <= pll_lock;
      lock_s    <= sync1;
      state     <= nxt_state;
      retry_cnt <= nxt_retry;
      cnt       <= (nxt_state != state) ? '0 : cnt + CW'(1);
      if (state == ST_READY && nxt_state == ST_READY && !lock_s)
        low_run <= low_run + 2'd1;
      else
        low_run <= 2'd0;
      // Outputs decode the next state so they change on the edge that enters it.
      pll_rst     <= (nxt_state == ST_RESET) || (nxt_state == ST_FAIL);
      video_rst_n <= (nxt_state == ST_READY);
      pll_ready   <= (nxt_state == ST_READY);
      fail        <= (nxt_state == ST_FAIL);
    end
  end

endmodule
